ddr3_read: RTL and testbench
============================

DDR3_READ -- requirements
Module: ddr3_read

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have port: rstn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have upstream request ports: RD_ADDR in 28 (32-bit word address); RD_LEN in 8 (words-1); RD_ID in 4; RD_ADDR_VALID in 1; RD_ADDR_READY out 1.
REQ-004 SHALL have upstream data ports: RD_DATA out 32; RD_BACK_ID out 4; RD_DATA_VALID out 1; RD_DATA_READY in 1; RD_DATA_LAST out 1.
REQ-005 SHALL have DDR request ports: READ_ADDR out 28 (bits[2:0]=0); READ_LEN out 4 (beats-1, max 15); READ_ID out 4; READ_ADDR_VALID out 1; READ_ADDR_READY in 1.
REQ-006 SHALL have DDR data ports: READ_DATA in 256; READ_BACK_ID in 4; READ_DATA_VALID in 1; READ_DATA_READY out 1; READ_DATA_LAST in 1.

Function
REQ-007 SHALL accept one request per transaction: RD_ADDR_READY high only in state IDLE; handshake latches addr, len, id; end = RD_ADDR+RD_LEN (mod 2^28).
REQ-008 SHALL compute total beats = end[27:3]-RD_ADDR[27:3]+1 (6 bits, 1..33), head skip = RD_ADDR[2:0], tail keep = end[2:0].
REQ-009 SHALL use states IDLE, CREDIT, ADDR, RECV, DRAIN; IDLE->CREDIT on request handshake.
REQ-010 CREDIT->ADDR when free FIFO entries >= min(remaining beats,16); else hold.
REQ-011 ADDR: READ_ADDR_VALID=1, READ_ADDR=aligned chunk address, READ_LEN=min(remaining,16)-1, READ_ID=latched id; ->RECV on handshake; VALID and payload stable until handshake.
REQ-012 RECV: READ_DATA_READY=1; each READ_DATA_VALID beat written to FIFO; on beat with READ_DATA_LAST: remaining-=chunk, address+=chunk*8; ->CREDIT if remaining>0 else DRAIN.
REQ-013 DRAIN->IDLE in the cycle after upstream handshake of RD_DATA_LAST.
REQ-014 READ_DATA_READY SHALL be 0 outside RECV; READ_BACK_ID not checked (DDR in-order).
REQ-015 Serializer SHALL pop one beat into a 256-bit holding register and emit word i = bits[32i+31:32i], i ascending.
REQ-016 First beat SHALL start at word head skip; last beat SHALL stop after word tail keep; single-beat case applies both.
REQ-017 RD_DATA_VALID high while holding register has a kept word; advance only on RD_DATA_VALID&&RD_DATA_READY; RD_DATA and VALID stable while stalled.
REQ-018 RD_DATA_LAST SHALL be high exactly on the final kept word (count = RD_LEN+1 words); RD_BACK_ID = latched id.
REQ-019 Next beat SHALL be popped in same cycle as last word of holding register is accepted (no bubble when FIFO non-empty); first RD_DATA_VALID no earlier than 1 cycle after first DDR beat handshake.
REQ-020 FIFO SHALL never overflow (credit rule); READ_DATA_VALID with READ_DATA_READY=0 is ignored.
REQ-021 Address arithmetic SHALL wrap modulo 2^28; no 4KB/row boundary splitting.

Reset
REQ-022 rstn low SHALL immediately set state IDLE, FIFO empty, counters 0, holding register invalid.
REQ-023 During reset all outputs SHALL be 0 (RD_ADDR_READY 0, READ_ADDR 0, READ_LEN 0); RD_ADDR_READY rises first clock after deassertion.
REQ-024 Reset mid-transaction SHALL abandon it; in-flight DDR beats after reset are not accepted (READY=0 in IDLE).

Structure
REQ-025 Shared package ddr3_pkg SHALL hold ADDR_W=28, WORD_W=32, BEAT_W=256, WORDS_PER_BEAT=8, MAX_BURST=16, RD_FIFO_DEPTH=32, state encoding.
REQ-026 SHALL instantiate one sub-module fifo_ddr3_read: 256-bit x32 synchronous FIFO with occupancy count output, same clk/rstn.

Verification
REQ-027 addr=0x10, len=7, READY always 1 -> one DDR read addr 0x10 len 0; words 0..7 in order; LAST on 8th word; back to IDLE.
REQ-028 addr=0x06, len=3 -> beats 2, READ_LEN=1; emit words 6,7 of beat0 then 0,1 of beat1; LAST on 4th.
REQ-029 addr=0x05, len=0 -> one beat, only word 5 emitted with VALID+LAST together.
REQ-030 addr=0x03, len=255 -> 33 beats as chunks 16,16,1 at 0x00,0x80,0x100; 256 words; RD_DATA_READY toggled 50% -> no loss, no FIFO overflow, no CREDIT->ADDR without space.
REQ-031 READ_ADDR_READY held low 10 cycles -> READ_ADDR_VALID/ADDR/LEN stable throughout.
REQ-032 rstn pulsed low mid-RECV of len=127 -> all outputs 0 immediately; new request addr=0 len=7 after release completes correctly.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared constants, FSM state type and burst helper for the DDR3 read path.
package ddr3_pkg;

  localparam int unsigned ADDR_W         = 28;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BEAT_W         = 256;
  localparam int unsigned WORDS_PER_BEAT = 8;
  localparam int unsigned MAX_BURST      = 16;
  localparam int unsigned RD_FIFO_DEPTH  = 32;
  localparam int unsigned CNT_W          = $clog2(RD_FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CREDIT = 3'd1,
    ADDR   = 3'd2,
    RECV   = 3'd3,
    DRAIN  = 3'd4
  } rd_state_t;

  // Beats in the next DDR burst: remaining beats capped at one maximum burst.
  function automatic logic [4:0] chunk_beats(input logic [5:0] remaining);
    return (remaining > 6'(MAX_BURST)) ? 5'(MAX_BURST) : remaining[4:0];
  endfunction

endpackage

// File: rtl/fifo_ddr3_read.sv
// Show-ahead synchronous FIFO buffering DDR beats ahead of the word serializer.
module fifo_ddr3_read
  import ddr3_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wr_en,
  input  logic [BEAT_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [BEAT_W-1:0] o_rd_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty
);

  localparam int unsigned PTR_W = $clog2(RD_FIFO_DEPTH);

  logic [BEAT_W-1:0] r_mem [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_full;
  logic              w_wr;
  logic              w_rd;

  assign w_full  = (r_count == CNT_W'(RD_FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_wr_en && !w_full;
  assign w_rd    = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/ddr3_read.sv
// Splits a word-granular read into <=16-beat DDR bursts, buffers the beats and
// serializes them back into 32-bit words, trimming head and tail of the range.
module ddr3_read
  import ddr3_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] RD_ADDR,
  input  logic [7:0]        RD_LEN,
  input  logic [3:0]        RD_ID,
  input  logic              RD_ADDR_VALID,
  output logic              RD_ADDR_READY,
  output logic [WORD_W-1:0] RD_DATA,
  output logic [3:0]        RD_BACK_ID,
  output logic              RD_DATA_VALID,
  input  logic              RD_DATA_READY,
  output logic              RD_DATA_LAST,
  output logic [ADDR_W-1:0] READ_ADDR,
  output logic [3:0]        READ_LEN,
  output logic [3:0]        READ_ID,
  output logic              READ_ADDR_VALID,
  input  logic              READ_ADDR_READY,
  input  logic [BEAT_W-1:0] READ_DATA,
  input  logic [3:0]        READ_BACK_ID,
  input  logic              READ_DATA_VALID,
  output logic              READ_DATA_READY,
  input  logic              READ_DATA_LAST
);

  rd_state_t         r_state;
  rd_state_t         w_next;
  logic              r_out_en;
  logic [3:0]        r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [5:0]        r_remaining;
  logic [5:0]        r_total;
  logic [2:0]        r_head;
  logic [2:0]        r_tail;

  logic [BEAT_W-1:0] r_hold;
  logic              r_hold_valid;
  logic              r_hold_last;
  logic [2:0]        r_widx;
  logic [2:0]        r_wend;
  logic [5:0]        r_ser_beat;

  logic [8:0]        w_end_lo;
  logic [5:0]        w_beats;
  logic [4:0]        w_chunk;
  logic              w_req_fire;
  logic              w_beat_in;
  logic              w_fire;
  logic              w_hold_end;
  logic              w_pop;
  logic              w_pop_first;
  logic              w_pop_last;
  logic [BEAT_W-1:0] w_fifo_rdata;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [CNT_W-1:0]  w_free;
  logic              w_fifo_empty;
  logic              w_unused;

  // DDR returns beats in order, so the echoed id carries no information.
  assign w_unused = ^READ_BACK_ID;

  // Beat count only needs the low address bits: the true span is at most 33.
  assign w_end_lo   = RD_ADDR[8:0] + {1'b0, RD_LEN};
  assign w_beats    = w_end_lo[8:3] - RD_ADDR[8:3] + 6'd1;
  assign w_chunk    = chunk_beats(r_remaining);
  assign w_free     = CNT_W'(RD_FIFO_DEPTH) - w_fifo_count;
  assign w_req_fire = RD_ADDR_VALID && RD_ADDR_READY;
  assign w_beat_in  = (r_state == RECV) && READ_DATA_VALID;

  assign RD_ADDR_READY   = r_out_en && (r_state == IDLE);
  assign READ_ADDR_VALID = (r_state == ADDR);
  assign READ_ADDR       = (r_state == ADDR) ? r_addr : '0;
  assign READ_LEN        = (r_state == ADDR) ? 4'(w_chunk - 5'd1) : '0;
  assign READ_ID         = r_id;
  assign READ_DATA_READY = (r_state == RECV);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_en <= 1'b0;
      r_state  <= IDLE;
    end else begin
      r_out_en <= 1'b1;
      r_state  <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req_fire) w_next = CREDIT;
      CREDIT:  if (w_free >= CNT_W'(w_chunk)) w_next = ADDR;
      ADDR:    if (READ_ADDR_READY) w_next = RECV;
      RECV:    if (w_beat_in && READ_DATA_LAST)
                 w_next = (r_remaining == {1'b0, w_chunk}) ? DRAIN : CREDIT;
      DRAIN:   if (w_fire && RD_DATA_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_id        <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_total     <= '0;
      r_head      <= '0;
      r_tail      <= '0;
    end else if ((r_state == IDLE) && w_req_fire) begin
      r_id        <= RD_ID;
      r_addr      <= {RD_ADDR[ADDR_W-1:3], 3'b000};
      r_remaining <= w_beats;
      r_total     <= w_beats;
      r_head      <= RD_ADDR[2:0];
      r_tail      <= w_end_lo[2:0];
    end else if (w_beat_in && READ_DATA_LAST) begin
      r_remaining <= r_remaining - {1'b0, w_chunk};
      r_addr      <= r_addr + ADDR_W'({w_chunk, 3'b000});
    end
  end

  fifo_ddr3_read u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .i_wr_en   (w_beat_in),
    .i_wr_data (READ_DATA),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rdata),
    .o_count   (w_fifo_count),
    .o_empty   (w_fifo_empty)
  );

  assign w_fire      = r_hold_valid && RD_DATA_READY;
  assign w_hold_end  = (r_widx == r_wend);
  // Refill on the same edge the final held word leaves, so no idle cycle.
  assign w_pop       = !w_fifo_empty && (!r_hold_valid || (w_fire && w_hold_end));
  assign w_pop_first = (r_ser_beat == '0);
  assign w_pop_last  = (r_ser_beat == r_total - 6'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_hold_last  <= 1'b0;
      r_widx       <= '0;
      r_wend       <= '0;
      r_ser_beat   <= '0;
    end else begin
      if (w_req_fire)  r_ser_beat <= '0;
      else if (w_pop)  r_ser_beat <= r_ser_beat + 6'd1;

      if (w_pop) begin
        r_hold       <= w_fifo_rdata;
        r_hold_valid <= 1'b1;
        r_hold_last  <= w_pop_last;
        r_widx       <= w_pop_first ? r_head : 3'd0;
        r_wend       <= w_pop_last  ? r_tail : 3'd7;
      end else if (w_fire) begin
        if (w_hold_end) r_hold_valid <= 1'b0;
        else            r_widx       <= r_widx + 3'd1;
      end
    end
  end

  assign RD_DATA       = r_hold[{r_widx, 5'b00000} +: WORD_W];
  assign RD_DATA_VALID = r_hold_valid;
  assign RD_DATA_LAST  = r_hold_valid && r_hold_last && w_hold_end;
  assign RD_BACK_ID    = r_id;

endmodule

// File: tb/tb_ddr3_read.sv
// Bench for ddr3_read: randomized DDR responder and consumer checked against
// an address-level model (word at address A is a fixed function of A).
module tb_ddr3_read;
  import ddr3_pkg::*;

  logic              clk = 1'b0;
  logic              rstn;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [7:0]        RD_LEN;
  logic [3:0]        RD_ID;
  logic              RD_ADDR_VALID;
  logic              RD_ADDR_READY;
  logic [WORD_W-1:0] RD_DATA;
  logic [3:0]        RD_BACK_ID;
  logic              RD_DATA_VALID;
  logic              RD_DATA_READY;
  logic              RD_DATA_LAST;
  logic [ADDR_W-1:0] READ_ADDR;
  logic [3:0]        READ_LEN;
  logic [3:0]        READ_ID;
  logic              READ_ADDR_VALID;
  logic              READ_ADDR_READY;
  logic [BEAT_W-1:0] READ_DATA;
  logic [3:0]        READ_BACK_ID;
  logic              READ_DATA_VALID;
  logic              READ_DATA_READY;
  logic              READ_DATA_LAST;

  ddr3_read dut (
    .clk(clk), .rstn(rstn),
    .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN), .RD_ID(RD_ID),
    .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
    .RD_DATA(RD_DATA), .RD_BACK_ID(RD_BACK_ID), .RD_DATA_VALID(RD_DATA_VALID),
    .RD_DATA_READY(RD_DATA_READY), .RD_DATA_LAST(RD_DATA_LAST),
    .READ_ADDR(READ_ADDR), .READ_LEN(READ_LEN), .READ_ID(READ_ID),
    .READ_ADDR_VALID(READ_ADDR_VALID), .READ_ADDR_READY(READ_ADDR_READY),
    .READ_DATA(READ_DATA), .READ_BACK_ID(READ_BACK_ID),
    .READ_DATA_VALID(READ_DATA_VALID), .READ_DATA_READY(READ_DATA_READY),
    .READ_DATA_LAST(READ_DATA_LAST)
  );

  always #5 clk = ~clk;

  typedef struct { logic [27:0] a; logic [3:0] l; logic [3:0] id; } req_t;
  typedef struct { logic [27:0] a; logic last; } beat_t;

  int    checks = 0;
  int    errors = 0;
  req_t  exp_q[$];
  beat_t beats[$];
  int    ardy_pct     = 75;
  int    ardy_hold    = 0;
  int    data_gap_pct = 25;
  bit    ddr_flush    = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wf(input logic [27:0] a);
    return {4'h0, a} * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {RD_ADDR_READY, RD_DATA, RD_BACK_ID, RD_DATA_VALID, RD_DATA_LAST,
              READ_ADDR, READ_LEN, READ_ID, READ_ADDR_VALID, READ_DATA_READY}, '0);
  endtask

  // DDR memory responder: random address/data handshakes, in-order beats.
  initial begin : ddr_slave
    bit          pv, pr, dv, dr;
    logic [27:0] pa;
    logic [3:0]  pl, pid;
    int          held;
    req_t        e;
    beat_t       b;
    READ_ADDR_READY = 1'b0; READ_DATA_VALID = 1'b0; READ_DATA = '0;
    READ_DATA_LAST  = 1'b0; READ_BACK_ID    = '0;
    pv = 0; pr = 0; dv = 0; dr = 0; held = 0; pa = '0; pl = '0; pid = '0;
    forever begin
      @(negedge clk);
      if (ddr_flush) begin
        beats.delete();
        READ_ADDR_READY = 1'b0; READ_DATA_VALID = 1'b0; READ_DATA_LAST = 1'b0;
        pv = 0; pr = 0; dv = 0; dr = 0; held = 0;
      end else begin
        if (pv && pr) begin
          chk("ddr_req_expected", 128'(exp_q.size() != 0), 128'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ddr_addr", pa, e.a);
            chk("ddr_len", pl, e.l);
            chk("ddr_id", pid, e.id);
          end
          for (int k = 0; k <= int'(pl); k++) begin
            b.a = pa + 28'(k * 8);
            b.last = (k == int'(pl));
            beats.push_back(b);
          end
          held = 0;
        end else if (pv && !pr) begin
          chk("ddr_addr_stable", {READ_ADDR_VALID, READ_ADDR, READ_LEN, READ_ID},
              {1'b1, pa, pl, pid});
        end
        if (dv && dr) void'(beats.pop_front());

        pv = READ_ADDR_VALID; pa = READ_ADDR; pl = READ_LEN; pid = READ_ID;
        if (pv && held < ardy_hold) begin
          READ_ADDR_READY = 1'b0;
          held++;
        end else begin
          READ_ADDR_READY = ($urandom_range(0, 99) < ardy_pct);
        end
        pr = READ_ADDR_READY;

        if (beats.size() == 0) begin
          READ_DATA_VALID = 1'b0;
        end else if (!(READ_DATA_VALID && !(dv && dr))) begin
          READ_DATA_VALID = ($urandom_range(0, 99) >= data_gap_pct);
          for (int i = 0; i < 8; i++) READ_DATA[32*i +: 32] = wf(beats[0].a + 28'(i));
          READ_DATA_LAST = beats[0].last;
          READ_BACK_ID   = 4'($urandom_range(0, 15));
        end
        dv = READ_DATA_VALID; dr = READ_DATA_READY;
      end
    end
  end

  task automatic run_txn(input logic [27:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input int rdy_pct, input int abort_after);
    logic [27:0] endw, a;
    logic [24:0] bd;
    logic [31:0] pd;
    int          rem, c, n, k, cyc, nwords;
    bit          pvv, prr, rdy, plast;
    req_t        r;
    endw = addr + 28'(len);
    bd   = endw[27:3] - addr[27:3];
    rem  = int'(bd) + 1;
    a    = {addr[27:3], 3'b000};
    while (rem > 0) begin
      c = (rem > 16) ? 16 : rem;
      r.a = a; r.l = 4'(c - 1); r.id = id;
      exp_q.push_back(r);
      a   = a + 28'(c * 8);
      rem = rem - c;
    end

    @(negedge clk);
    RD_ADDR = addr; RD_LEN = len; RD_ID = id; RD_ADDR_VALID = 1'b1;
    n = 0;
    while (RD_ADDR_READY !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_accepted", 128'(n < 50), 128'd1);
    @(negedge clk);
    RD_ADDR_VALID = 1'b0;

    nwords = int'(len) + 1;
    k = 0; cyc = 0; pvv = 0; prr = 0; pd = '0; plast = 0;
    while (k < nwords && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (abort_after > 0 && cyc >= abort_after) return;
      if (pvv && !prr)
        chk("rd_stall_stable", {RD_DATA_VALID, RD_DATA, RD_DATA_LAST}, {1'b1, pd, plast});
      rdy = ($urandom_range(0, 99) < rdy_pct);
      RD_DATA_READY = rdy;
      if (RD_DATA_VALID && rdy) begin
        chk("rd_data", RD_DATA, wf(addr + 28'(k)));
        chk("rd_last", RD_DATA_LAST, (k == nwords - 1));
        chk("rd_id", RD_BACK_ID, id);
        k++;
      end
      pvv = RD_DATA_VALID; prr = rdy; pd = RD_DATA; plast = RD_DATA_LAST;
    end
    chk("rd_word_count", k, nwords);
    @(negedge clk);
    RD_DATA_READY = 1'b0;
    chk("back_to_idle", {RD_ADDR_READY, RD_DATA_VALID}, 2'b10);
    chk("ddr_reqs_issued", exp_q.size(), 0);
  endtask

  initial begin : main
    rstn = 1'b0;
    RD_ADDR = '0; RD_LEN = '0; RD_ID = '0; RD_ADDR_VALID = 1'b0; RD_DATA_READY = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    rstn = 1'b1;
    #1 chk("ready_low_before_edge", RD_ADDR_READY, 1'b0);
    @(negedge clk);
    chk("ready_after_first_edge", RD_ADDR_READY, 1'b1);

    ardy_pct = 100; data_gap_pct = 0;
    run_txn(28'h10, 8'd7, 4'h1, 100, 0);
    ardy_pct = 75; data_gap_pct = 25;
    run_txn(28'h06, 8'd3, 4'h2, 70, 0);
    run_txn(28'h05, 8'd0, 4'h3, 100, 0);
    run_txn(28'h03, 8'd255, 4'h4, 50, 0);
    ardy_hold = 10;
    run_txn(28'h1234, 8'd40, 4'h5, 80, 0);
    ardy_hold = 0;
    run_txn(28'hFFFFFFC, 8'd15, 4'h6, 60, 0);
    for (int t = 0; t < 5; t++)
      run_txn(28'($urandom), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
              $urandom_range(30, 100), 0);

    data_gap_pct = 60;
    run_txn(28'h40, 8'd127, 4'h9, 50, 12);
    rstn = 1'b0;
    #1 chk_outputs_zero("midtxn_reset_outputs");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_accept_in_reset", READ_DATA_READY, 1'b0);
    end
    ddr_flush = 1'b1;
    exp_q.delete();
    RD_DATA_READY = 1'b0;
    repeat (2) @(negedge clk);
    ddr_flush = 1'b0;
    data_gap_pct = 25;
    rstn = 1'b1;
    #1 chk("ready_low_after_release", RD_ADDR_READY, 1'b0);
    @(negedge clk);
    chk("ready_after_release_edge", RD_ADDR_READY, 1'b1);
    run_txn(28'h0, 8'd7, 4'hA, 70, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
